// File: rtl/lfsr_pkg.sv
// Shared types for the PRBS generator: selects between the two LFSR structures.
package lfsr_pkg;

  typedef enum logic {
    LFSR_FIBONACCI = 1'b0,
    LFSR_GALOIS    = 1'b1
  } lfsr_mode_t;

endpackage

// File: rtl/lfsr_next_state.sv
// Combinational one-step LFSR transition for either Fibonacci or Galois structure.
module lfsr_next_state
  import lfsr_pkg::*;
#(
  parameter int         N    = 8,
  parameter logic [N-1:0] TAPS = 8'h71,
  parameter lfsr_mode_t MODE = LFSR_FIBONACCI
) (
  input  logic [N-1:0] state,
  output logic [N-1:0] next
);

  generate
    if (MODE == LFSR_GALOIS) begin : g_galois
      genvar gi;
      // Each bit takes its upper neighbour, flipped by the tap when the bit shifted out is 1.
      for (gi = 0; gi < N - 1; gi++) begin : g_bit
        assign next[gi] = state[gi+1] ^ (TAPS[gi] & state[0]);
      end
      assign next[N-1] = TAPS[N-1] & state[0];
    end else begin : g_fibonacci
      assign next = {^(state & TAPS), state[N-1:1]};
    end
  endgenerate

endmodule

// File: rtl/lfsr_prbs.sv
// PRBS generator: state/seed registers, load/recovery/step priority and period monitor.
module lfsr_prbs
  import lfsr_pkg::*;
#(
  parameter int           N            = 8,
  parameter logic [N-1:0] TAPS         = 8'h71,
  parameter lfsr_mode_t   MODE         = LFSR_FIBONACCI,
  parameter logic [N-1:0] RESET_SEED   = {{(N-1){1'b0}}, 1'b1},
  parameter bit           AUTO_RECOVER = 1'b1,
  parameter logic [N-1:0] RECOVER_SEED = {{(N-1){1'b0}}, 1'b1}
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         load,
  input  logic [N-1:0] seed,
  output logic         out,
  output logic [N-1:0] state,
  output logic         locked,
  output logic         recovered,
  output logic         wrap,
  output logic [N-1:0] period,
  output logic         period_valid
);

  logic [N-1:0] state_reg;
  logic [N-1:0] seed_reg;
  logic [N-1:0] step_count_reg;
  logic [N-1:0] period_reg;
  logic         period_valid_reg;
  logic         recovered_reg;
  logic         wrap_reg;
  logic [N-1:0] state_next;
  logic         recover_now;

  lfsr_next_state #(
    .N    (N),
    .TAPS (TAPS),
    .MODE (MODE)
  ) u_next (
    .state (state_reg),
    .next  (state_next)
  );

  assign locked      = (state_reg == '0);
  assign recover_now = AUTO_RECOVER && locked && ena;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= RESET_SEED;
      seed_reg         <= RESET_SEED;
      step_count_reg   <= '0;
      period_reg       <= '0;
      period_valid_reg <= 1'b0;
      recovered_reg    <= 1'b0;
      wrap_reg         <= 1'b0;
    end else begin
      recovered_reg <= 1'b0;
      wrap_reg      <= 1'b0;
      if (load) begin
        state_reg        <= seed;
        seed_reg         <= seed;
        step_count_reg   <= '0;
        period_valid_reg <= 1'b0;
      end else if (recover_now) begin
        state_reg      <= RECOVER_SEED;
        seed_reg       <= RECOVER_SEED;
        step_count_reg <= '0;
        recovered_reg  <= 1'b1;
      end else if (ena) begin
        state_reg <= state_next;
        // A locked all-zero register is a fixed point, not a completed cycle.
        if (!locked && state_next == seed_reg) begin
          wrap_reg         <= 1'b1;
          period_reg       <= step_count_reg + 1'b1;
          period_valid_reg <= 1'b1;
          step_count_reg   <= '0;
        end else if (step_count_reg != '1) begin
          step_count_reg <= step_count_reg + 1'b1;
        end
      end
    end
  end

  assign out          = state_reg[0];
  assign state        = state_reg;
  assign recovered    = recovered_reg;
  assign wrap         = wrap_reg;
  assign period       = period_reg;
  assign period_valid = period_valid_reg;

endmodule

// File: tb/tb_lfsr_prbs.sv
// Bench for lfsr_prbs: four configurations checked every cycle against an arithmetic model.
module tb_lfsr_prbs;
  import lfsr_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_v[4];
  logic       ena_v[4];
  logic       load_v[4];
  logic [7:0] seed_v[4];

  logic [2:0] st0, per0, st1, per1, st2, per2;
  logic [7:0] st3, per3;
  logic out0, lk0, rc0, wr0, pv0;
  logic out1, lk1, rc1, wr1, pv1;
  logic out2, lk2, rc2, wr2, pv2;
  logic out3, lk3, rc3, wr3, pv3;

  // 0: N=3 Fibonacci 101, 1: N=3 Galois 110, 2: N=3 Fibonacci no recovery, 3: defaults
  lfsr_prbs #(.N(3), .TAPS(3'b101), .MODE(LFSR_FIBONACCI), .RESET_SEED(3'b001),
              .AUTO_RECOVER(1'b1), .RECOVER_SEED(3'b001)) u_f3 (
    .clk(clk), .rst(rst_v[0]), .ena(ena_v[0]), .load(load_v[0]), .seed(seed_v[0][2:0]),
    .out(out0), .state(st0), .locked(lk0), .recovered(rc0), .wrap(wr0),
    .period(per0), .period_valid(pv0));

  lfsr_prbs #(.N(3), .TAPS(3'b110), .MODE(LFSR_GALOIS), .RESET_SEED(3'b001),
              .AUTO_RECOVER(1'b1), .RECOVER_SEED(3'b001)) u_g3 (
    .clk(clk), .rst(rst_v[1]), .ena(ena_v[1]), .load(load_v[1]), .seed(seed_v[1][2:0]),
    .out(out1), .state(st1), .locked(lk1), .recovered(rc1), .wrap(wr1),
    .period(per1), .period_valid(pv1));

  lfsr_prbs #(.N(3), .TAPS(3'b101), .MODE(LFSR_FIBONACCI), .RESET_SEED(3'b001),
              .AUTO_RECOVER(1'b0), .RECOVER_SEED(3'b001)) u_f3n (
    .clk(clk), .rst(rst_v[2]), .ena(ena_v[2]), .load(load_v[2]), .seed(seed_v[2][2:0]),
    .out(out2), .state(st2), .locked(lk2), .recovered(rc2), .wrap(wr2),
    .period(per2), .period_valid(pv2));

  lfsr_prbs u_d8 (
    .clk(clk), .rst(rst_v[3]), .ena(ena_v[3]), .load(load_v[3]), .seed(seed_v[3]),
    .out(out3), .state(st3), .locked(lk3), .recovered(rc3), .wrap(wr3),
    .period(per3), .period_valid(pv3));

  logic [7:0] o_state[4], o_period[4];
  logic       o_out[4], o_locked[4], o_rec[4], o_wrap[4], o_pv[4];
  assign o_state[0] = {5'd0, st0}; assign o_period[0] = {5'd0, per0};
  assign o_state[1] = {5'd0, st1}; assign o_period[1] = {5'd0, per1};
  assign o_state[2] = {5'd0, st2}; assign o_period[2] = {5'd0, per2};
  assign o_state[3] = st3;         assign o_period[3] = per3;
  assign o_out[0] = out0; assign o_locked[0] = lk0; assign o_rec[0] = rc0; assign o_wrap[0] = wr0; assign o_pv[0] = pv0;
  assign o_out[1] = out1; assign o_locked[1] = lk1; assign o_rec[1] = rc1; assign o_wrap[1] = wr1; assign o_pv[1] = pv1;
  assign o_out[2] = out2; assign o_locked[2] = lk2; assign o_rec[2] = rc2; assign o_wrap[2] = wr2; assign o_pv[2] = pv2;
  assign o_out[3] = out3; assign o_locked[3] = lk3; assign o_rec[3] = rc3; assign o_wrap[3] = wr3; assign o_pv[3] = pv3;

  int cfg_n[4]    = '{3, 3, 3, 8};
  int cfg_taps[4] = '{5, 6, 5, 'h71};
  int cfg_gal[4]  = '{0, 1, 0, 0};
  int cfg_ar[4]   = '{1, 1, 0, 1};

  int m_state[4], m_seed[4], m_steps[4], m_period[4], m_pv[4], m_rec[4], m_wrap[4];
  int d8_total = 0;
  int d8_locked_seen = 0;
  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  function automatic int lfsr_step(int n, int taps, int gal, int s);
    int fb;
    if (gal != 0) return (s >> 1) ^ (((s & 1) != 0) ? taps : 0);
    fb = $countones(s & taps) & 1;
    return (s >> 1) | (fb << (n - 1));
  endfunction

  task automatic model_step();
    int mask, ns;
    for (int i = 0; i < 4; i++) begin
      mask = (1 << cfg_n[i]) - 1;
      m_rec[i] = 0;
      m_wrap[i] = 0;
      if (rst_v[i]) begin
        m_state[i] = 1; m_seed[i] = 1; m_steps[i] = 0; m_period[i] = 0; m_pv[i] = 0;
      end else if (load_v[i]) begin
        m_state[i] = int'(seed_v[i]) & mask; m_seed[i] = m_state[i]; m_steps[i] = 0; m_pv[i] = 0;
      end else if (ena_v[i]) begin
        if (m_state[i] == 0 && cfg_ar[i] != 0) begin
          m_state[i] = 1; m_seed[i] = 1; m_steps[i] = 0; m_rec[i] = 1;
        end else if (m_state[i] == 0) begin
          m_steps[i]++;
        end else begin
          ns = lfsr_step(cfg_n[i], cfg_taps[i], cfg_gal[i], m_state[i]);
          m_steps[i]++;
          if (ns == m_seed[i]) begin
            m_wrap[i] = 1; m_period[i] = m_steps[i] & mask; m_pv[i] = 1; m_steps[i] = 0;
          end
          m_state[i] = ns;
          if (i == 3) d8_total++;
        end
      end
    end
  endtask

  task automatic chk(string name, int inst, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s inst%0d: got %0d expected %0d at %0t", name, inst, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 4; i++) begin
      chk("state", i, int'(o_state[i]), m_state[i]);
      chk("out", i, int'(o_out[i]), m_state[i] & 1);
      chk("locked", i, int'(o_locked[i]), (m_state[i] == 0) ? 1 : 0);
      chk("recovered", i, int'(o_rec[i]), m_rec[i]);
      chk("wrap", i, int'(o_wrap[i]), m_wrap[i]);
      chk("period_valid", i, int'(o_pv[i]), m_pv[i]);
      chk("period", i, int'(o_period[i]), m_period[i]);
    end
    if (o_locked[3]) d8_locked_seen = 1;
  endtask

  task automatic tick();
    @(negedge clk);
    if (chk_en) compare_all();
    @(posedge clk);
    model_step();
    #2;
  endtask

  int exp_f[7] = '{3'b100, 3'b110, 3'b111, 3'b011, 3'b101, 3'b010, 3'b001};
  int exp_fo[7] = '{0, 0, 1, 1, 1, 0, 1};
  int exp_g[7] = '{3'b110, 3'b011, 3'b111, 3'b101, 3'b100, 3'b010, 3'b001};

  initial begin
    int guard;
    for (int i = 0; i < 4; i++) begin
      rst_v[i] = 1'b1; ena_v[i] = 1'b0; load_v[i] = 1'b0; seed_v[i] = 8'd0;
    end
    tick();
    tick();
    for (int i = 0; i < 4; i++) rst_v[i] = 1'b0;
    chk_en = 1'b1;
    chk("reset_state", 0, int'(o_state[0]), 1);
    chk("reset_out", 0, int'(o_out[0]), 1);
    chk("reset_pv", 0, int'(o_pv[0]), 0);
    chk("reset_period", 3, int'(o_period[3]), 0);
    $display("reset released: f3 state=%b d8 state=%h", st0, st3);
    ena_v[3] = 1'b1;

    ena_v[0] = 1'b1;
    for (int k = 0; k < 7; k++) begin
      tick();
      $display("fib step %0d: state=%b out=%b wrap=%b", k + 1, st0, out0, wr0);
      chk("fib_state", 0, int'(o_state[0]), exp_f[k]);
      chk("fib_out", 0, int'(o_out[0]), exp_fo[k]);
      chk("fib_wrap", 0, int'(o_wrap[0]), (k == 6) ? 1 : 0);
    end
    ena_v[0] = 1'b0;
    chk("fib_period", 0, int'(o_period[0]), 7);
    chk("fib_pv", 0, int'(o_pv[0]), 1);

    load_v[1] = 1'b1; seed_v[1] = 8'd1;
    tick();
    load_v[1] = 1'b0; ena_v[1] = 1'b1;
    for (int k = 0; k < 7; k++) begin
      tick();
      $display("galois step %0d: state=%b wrap=%b", k + 1, st1, wr1);
      chk("gal_state", 1, int'(o_state[1]), exp_g[k]);
      chk("gal_wrap", 1, int'(o_wrap[1]), (k == 6) ? 1 : 0);
    end
    ena_v[1] = 1'b0;
    chk("gal_period", 1, int'(o_period[1]), 7);

    load_v[0] = 1'b1; seed_v[0] = 8'd0;
    tick();
    load_v[0] = 1'b0;
    $display("zero seed loaded: state=%b locked=%b", st0, lk0);
    chk("zero_locked", 0, int'(o_locked[0]), 1);
    chk("zero_pv", 0, int'(o_pv[0]), 0);
    ena_v[0] = 1'b1;
    tick();
    ena_v[0] = 1'b0;
    $display("recovery: state=%b recovered=%b", st0, rc0);
    chk("recover_state", 0, int'(o_state[0]), 1);
    chk("recover_pulse", 0, int'(o_rec[0]), 1);
    chk("recover_pv", 0, int'(o_pv[0]), 0);
    tick();
    chk("recover_drop", 0, int'(o_rec[0]), 0);

    load_v[2] = 1'b1; seed_v[2] = 8'd0;
    tick();
    load_v[2] = 1'b0; ena_v[2] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      $display("no-recover step %0d: state=%b locked=%b wrap=%b", k + 1, st2, lk2, wr2);
      chk("stuck_state", 2, int'(o_state[2]), 0);
      chk("stuck_locked", 2, int'(o_locked[2]), 1);
      chk("stuck_wrap", 2, int'(o_wrap[2]), 0);
    end
    ena_v[2] = 1'b0;

    load_v[0] = 1'b1; ena_v[0] = 1'b1; seed_v[0] = 8'd3;
    tick();
    load_v[0] = 1'b0; ena_v[0] = 1'b0;
    $display("load with ena: state=%b", st0);
    chk("load_over_ena", 0, int'(o_state[0]), 3);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("hold_state", 0, int'(o_state[0]), 3);
      chk("hold_wrap", 0, int'(o_wrap[0]), 0);
    end
    ena_v[0] = 1'b1;
    for (int k = 0; k < 7; k++) tick();
    $display("reseeded cycle: state=%b wrap=%b period=%0d", st0, wr0, per0);
    chk("reseed_wrap", 0, int'(o_wrap[0]), 1);
    chk("reseed_period", 0, int'(o_period[0]), 7);
    for (int k = 0; k < 6; k++) tick();
    ena_v[0] = 1'b0;
    chk("mid_state", 0, int'(o_state[0]), 7);

    rst_v[0] = 1'b1; load_v[0] = 1'b1; ena_v[0] = 1'b1; seed_v[0] = 8'd6;
    tick();
    rst_v[0] = 1'b0; load_v[0] = 1'b0; ena_v[0] = 1'b0;
    $display("reset over load: state=%b pv=%b", st0, pv0);
    chk("rst_state", 0, int'(o_state[0]), 1);
    chk("rst_pv", 0, int'(o_pv[0]), 0);
    chk("rst_wrap", 0, int'(o_wrap[0]), 0);

    guard = 0;
    while (o_wrap[3] == 1'b0 && guard < 400) begin
      tick();
      guard++;
    end
    ena_v[3] = 1'b0;
    $display("default free-run: wrap after %0d steps, period=%0d", d8_total, per3);
    chk("d8_wrap_seen", 3, int'(o_wrap[3]), 1);
    chk("d8_wrap_steps", 3, d8_total, 255);
    chk("d8_period", 3, int'(o_period[3]), 255);
    chk("d8_locked_seen", 3, d8_locked_seen, 0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lfsr_prbs.md
Name: lfsr_prbs

Overview:
- Parametrised linear-feedback shift register (PRBS generator) with parallel seed load, step enable and selectable Fibonacci/Galois structure.
- Adds all-zero lock-up detection with optional auto-recovery, and a period monitor that measures the steps taken to return to the loaded seed.
- Used as a test-pattern/scrambler source and as a self-checking pseudo-random stimulus generator in lab designs.

Parameters:
- N, 8, state width in bits (N >= 2).
- TAPS, 8'h71, N-bit tap mask. Fibonacci: bits XORed into feedback. Galois: mask XORed into shifted state when state[0]=1.
- MODE, LFSR_FIBONACCI, structure select (lfsr_mode_t).
- RESET_SEED, 1, state and seed_reg value after reset; must be nonzero.
- AUTO_RECOVER, 1, 1 = escape all-zero state automatically; 0 = remain locked.
- RECOVER_SEED, 1, state loaded on recovery; must be nonzero.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- ena  input  1  advance one step this cycle.
- load  input  1  parallel-load seed this cycle.
- seed  input  N  value captured on load.
- out  output  1  serial PRBS bit = state[0].
- state  output  N  current register contents.
- locked  output  1  state == 0 (combinational from register).
- recovered  output  1  one-cycle pulse: auto-recovery occurred last edge.
- wrap  output  1  one-cycle pulse: last step returned state to seed_reg.
- period  output  N  steps from seed back to seed; valid when period_valid.
- period_valid  output  1  period holds a measured value.

Behaviour:
- Single clock domain. Reset is synchronous and active-high: clk and rst, rst sampled on posedge clk only.
- Reset: state=RESET_SEED, seed_reg=RESET_SEED, step_count=0, period=0, period_valid=0, recovered=0, wrap=0.
- Priority per edge: rst > load > recovery > ena step > hold.
- Fibonacci next: fb = XOR(state & TAPS); next = {fb, state[N-1:1]}.
- Galois next: next = (state >> 1) ^ (state[0] ? TAPS : 0).
- load=1: state<=seed, seed_reg<=seed, step_count<=0, period_valid<=0. ena is ignored that cycle.
- Loading seed=0 is accepted; locked asserts the following cycle.
- Recovery: AUTO_RECOVER=1, locked=1, ena=1, load=0 -> state<=RECOVER_SEED, seed_reg<=RECOVER_SEED, step_count<=0, recovered<=1 for one cycle. Not counted as a step; period/period_valid unchanged.
- AUTO_RECOVER=0: all-zero state is a fixed point; ena steps leave state 0; locked stays 1.
- Step (ena=1, no load/recovery):
  - state<=next.
  - If next == seed_reg: wrap<=1, period<=step_count+1, period_valid<=1, step_count<=0.
  - Otherwise step_count increments, saturating at 2^N-1.
  - The saturated case covers a seed outside the cycle, which never wraps.
- ena=0: state, counters and period hold; recovered and wrap drop to 0.
- Latency: out/state reflect a step one edge after ena is sampled. Pulses are registered and align with the new state.
- Max-length period 2^N-1 fits in N bits; step_count+1 never exceeds it on wrap.
- rst mid-run overrides everything that edge, including load.

Decomposition:
- lfsr_pkg holds typedef enum lfsr_mode_t {LFSR_FIBONACCI, LFSR_GALOIS}.
- One combinational sub-module, lfsr_next_state (params N, TAPS, MODE; in state, out next), instantiated once. Top level holds registers, priority logic and the period monitor.

Test Plan:
- N=3, TAPS=3'b101, Fibonacci, reset then ena high 7 cycles -> state 001,100,110,111,011,101,010,001; out 1,0,0,1,1,1,0; wrap pulses on the 7th step; period=7, period_valid=1.
- N=3, TAPS=3'b110, Galois, load seed=001 then 7 steps -> 110,011,111,101,100,010,001; wrap on 7th step; period=7.
- Load seed=000 with AUTO_RECOVER=1, then ena=1 -> locked=1, next edge state=RECOVER_SEED=001, recovered pulses 1 cycle, period_valid=0. Repeat with AUTO_RECOVER=0 -> state stays 000 for 10 steps, locked stays 1, wrap never pulses.
- load=1 and ena=1 same cycle with seed=011 -> state=011 (no step), step_count=0. Then ena=0 for 5 cycles -> state holds 011, no pulses.
- Mid-sequence (state=111) assert rst with load=1, seed=110 -> state=RESET_SEED=001, period_valid=0, all pulses 0.
- Default N=8, TAPS=8'h71, Fibonacci, free-run from reset -> wrap after exactly 255 steps, period=255, locked never asserts.
